// File: rtl/muldiv_controller.sv
// Iterative M-extension sequencer for the EX stage: MUL/MULHU by shift-add,
// DIVU/REMU by restoring division, one bit per cycle, stalling the front end.
module muldiv_controller #(
   parameter int XLEN   = 32,
   parameter int ITER_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ex_valid,
   input  logic [1:0]      ex_op,
   input  logic [XLEN-1:0] ex_rs1_val,
   input  logic [XLEN-1:0] ex_rs2_val,
   input  logic            flush_ex,
   output logic            stall_md,
   output logic            busy,
   output logic            result_valid,
   output logic [XLEN-1:0] result
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [ITER_W-1:0]   cnt;
   logic [2*XLEN-1:0]   acc;
   logic [XLEN-1:0]     opa;
   logic [XLEN-1:0]     opb;
   logic [1:0]          op;

   logic                accept;
   logic                last;
   logic                div_zero;
   logic [2*XLEN-1:0]   acc_nxt;
   logic [XLEN-1:0]     opa_nxt;
   logic [XLEN-1:0]     opb_nxt;

   // Add the multiplicand into the upper half, then shift the whole pair right;
   // the add's carry lands in the MSB so no product bit is lost.
   function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] a,
                                                  input logic [XLEN-1:0]   mcand,
                                                  input logic              add);
      logic [XLEN:0] sum;
      sum = {1'b0, a[2*XLEN-1:XLEN]} + (add ? {1'b0, mcand} : {(XLEN+1){1'b0}});
      return {sum, a[XLEN-1:1]};
   endfunction

   // acc holds {remainder, quotient}; din is the next dividend bit shifted in.
   function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] a,
                                                  input logic              din,
                                                  input logic [XLEN-1:0]   divisor);
      logic [XLEN:0]   rem;
      logic [XLEN+1:0] diff;
      rem  = {a[2*XLEN-1:XLEN], din};
      diff = {1'b0, rem} - {2'b00, divisor};
      if (diff[XLEN+1])
         return {rem[XLEN-1:0], a[XLEN-2:0], 1'b0};
      else
         return {diff[XLEN-1:0], a[XLEN-2:0], 1'b1};
   endfunction

   assign accept   = (state == IDLE) && ex_valid && !flush_ex;
   assign last     = (cnt == {ITER_W{1'b1}});
   assign div_zero = ex_op[1] && (ex_rs2_val == '0);

   assign stall_md     = accept || ((state == RUN) && !flush_ex);
   assign result_valid = (state == DONE) && !flush_ex;

   // Dividend shifts out of opa's MSB; multiplier shifts out of opb's LSB.
   always_comb begin
      acc_nxt = acc;
      opa_nxt = opa;
      opb_nxt = opb;
      if (op[1]) begin
         acc_nxt = div_step(acc, opa[XLEN-1], opb);
         opa_nxt = {opa[XLEN-2:0], 1'b0};
      end else begin
         acc_nxt = mul_step(acc, opa, opb[0]);
         opb_nxt = {1'b0, opb[XLEN-1:1]};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         busy   <= 1'b0;
         result <= '0;
         cnt    <= '0;
         acc    <= '0;
         opa    <= '0;
         opb    <= '0;
         op     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  opa  <= ex_rs1_val;
                  opb  <= ex_rs2_val;
                  op   <= ex_op;
                  acc  <= '0;
                  cnt  <= '0;
                  busy <= 1'b1;
                  if (div_zero) begin
                     state  <= DONE;
                     result <= ex_op[0] ? ex_rs1_val : {XLEN{1'b1}};
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (flush_ex) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  acc <= acc_nxt;
                  opa <= opa_nxt;
                  opb <= opb_nxt;
                  cnt <= cnt + 1'b1;
                  if (last) begin
                     state  <= DONE;
                     result <= op[0] ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
